mlp_eval_sequencer: RTL and testbench
=====================================

# mlp_eval_sequencer

Synthesisable stimulus/response sequencer that replaces the file-driven bench loop around the combinational printed-MLP `top`. It accepts one flattened feature vector per handshake, drives the classifier input and waits a programmable settle time. It then captures the class output, compares it against either a label or a fault-free golden model, and streams the result out. Running mismatch statistics are kept for fault-injection campaigns.

## Interface
Parameters:
- `NUM_A`, 16, number of input features.
- `WIDTH_A`, 4, bits per feature.
- `OUTWIDTH`, 4, class output width.
- `SETTLE`, 8, cycles from applying a vector to capture; legal range ≥1.
- `CNTW`, 16, width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: sequencer can accept a sample.
- `s_inp` in NUM_A*WIDTH_A: flattened features; feature i is at `[(i+1)*WIDTH_A-1 : i*WIDTH_A]`.
- `s_label` in OUTWIDTH: expected class.
- `cmp_sel` in 1: compare source, sampled at accept; 0 = `s_label`, 1 = `gold_out`.
- `dut_inp` out NUM_A*WIDTH_A: registered drive to the classifier under test.
- `dut_out` in OUTWIDTH: class from the classifier under test, which may be faulty.
- `gold_out` in OUTWIDTH: class from the fault-free classifier driven by the same `dut_inp`.
- `r_valid` out 1: result valid.
- `r_ready` in 1: result consumer ready.
- `r_class` out OUTWIDTH: captured `dut_out`.
- `r_err` out 1: 1 if `r_class` ≠ selected reference.
- `sample_cnt` out CNTW: samples captured since reset or clear.
- `err_cnt` out CNTW: mismatches since reset or clear.
- `first_err_vld` out 1: at least one mismatch has been recorded.
- `first_err_idx` out CNTW: `sample_cnt` value (0-based) of the first mismatch.
- `cnt_clr` in 1: synchronous clear of the statistics.

## Operation
- Three-state FSM: IDLE, SETTLE, EMIT.
- IDLE:
  - `s_ready`=1 (forced 0 while `rst`=1).
  - On `s_valid`&`s_ready`: `dut_inp`←`s_inp`, latch `s_label` and `cmp_sel`, settle counter←SETTLE, go to SETTLE.
- SETTLE:
  - `s_ready`=0; the counter decrements each cycle.
  - On the edge where counter==1:
    - `r_class`←`dut_out`.
    - `r_err`←(`dut_out` ≠ ref), where ref is the latched label if `cmp_sel`=0 and live `gold_out` otherwise.
    - `r_valid`←1, go to EMIT.
- EMIT:
  - `r_valid`, `r_class` and `r_err` are held stable until `r_valid`&`r_ready`; then `r_valid`←0 and go to IDLE.
  - `s_valid` is ignored in EMIT.
- `dut_inp` holds the last applied vector indefinitely; it is never cleared except by reset. This keeps the classifier's nets static between samples.
- Statistics update on the capture edge:
  - `sample_cnt`+=1; `err_cnt`+=`r_err`.
  - Both counters saturate at 2^CNTW−1.
  - On the first mismatch after reset or clear: `first_err_idx`←pre-increment `sample_cnt`, `first_err_vld`←1.
  - Later mismatches leave `first_err_idx` unchanged.
- `cnt_clr`:
  - Zeroes `sample_cnt`, `err_cnt`, `first_err_vld` and `first_err_idx`.
  - Takes priority over a coincident capture; that sample is not counted.
  - Does not affect the FSM or the result outputs.

## Timing
- Reset values: state IDLE; `dut_inp`=0, `r_valid`=0, `r_class`=0, `r_err`=0; all counters 0; `first_err_vld`=0, `first_err_idx`=0.
- Reset mid-operation aborts the sample and produces no result.
- `s_ready`=1 on the first cycle after `rst` deasserts.
- With accept at edge t0:
  - `dut_inp` is valid after t0.
  - Capture occurs at edge t0+SETTLE.
  - `r_valid` is high from t0+SETTLE.
- Minimum period per sample is SETTLE+2 cycles (accept, SETTLE cycles, EMIT with `r_ready`=1, return to IDLE).
- `s_ready` is a pure decode of the state; there is no combinational path from `s_valid` or `r_ready` to any output except through registers.
- `gold_out` and `dut_out` must be stable at the capture edge. SETTLE is chosen by the integrator to cover the combinational delay of the classifier.

## Test plan
- Reset, then 1 cycle idle → `s_ready`=1, `r_valid`=0, all counters 0, `dut_inp`=0.
- SETTLE=3. Accept `s_inp`=0x0123456789ABCDEF with `s_label`=5, `cmp_sel`=0, while the stub drives `dut_out`=5.
  - Expect `dut_inp`=0x0123456789ABCDEF after the accept edge, and `r_valid` exactly 3 cycles after the accept edge.
  - Expect `r_class`=5, `r_err`=0, `sample_cnt`=1, `err_cnt`=0.
- Hold `r_ready`=0 for 10 cycles with `s_valid`=1 → `r_valid` and `r_class` remain stable, `s_ready`=0, and no second accept occurs.
- `cmp_sel`=1, `dut_out`=3, `gold_out`=7 on the 4th sample (0-based index 3) → `r_err`=1, `err_cnt`=1, `first_err_vld`=1, `first_err_idx`=3.
  - A later mismatch on sample 6 gives `err_cnt`=2 with `first_err_idx` still 3.
- CNTW=4. Run 20 mismatching samples → `sample_cnt`=15 and `err_cnt`=15 (saturated). Assert `cnt_clr` on a capture edge → both counters 0 and `first_err_vld`=0.
- Assert `rst` during SETTLE → no `r_valid` pulse, `dut_inp`=0, `s_ready`=1 one cycle after release.

Source files
------------

// File: rtl/mlp_eval_sequencer_if.sv
// -----------------------------------------------------------------------------
// mlp_eval_sequencer_if
// Bundles every handshake, classifier and statistics signal of the
// printed-MLP evaluation sequencer.
//   slave  : sequencer side (consumes samples, drives the classifier input,
//            produces results and statistics)
//   master : environment side (sample source, classifier stubs, result sink)
// Signals:
//   s_valid/s_ready/s_inp/s_label/cmp_sel : sample input handshake
//   dut_inp/dut_out/gold_out              : classifier under test and golden
//   r_valid/r_ready/r_class/r_err         : result output handshake
//   sample_cnt/err_cnt/first_err_vld/first_err_idx/cnt_clr : statistics
// -----------------------------------------------------------------------------
interface mlp_eval_sequencer_if #(
  parameter int NUM_A    = 16,
  parameter int WIDTH_A  = 4,
  parameter int OUTWIDTH = 4,
  parameter int CNTW     = 16
);
  logic                       s_valid;
  logic                       s_ready;
  logic [NUM_A*WIDTH_A-1:0]   s_inp;
  logic [OUTWIDTH-1:0]        s_label;
  logic                       cmp_sel;
  logic [NUM_A*WIDTH_A-1:0]   dut_inp;
  logic [OUTWIDTH-1:0]        dut_out;
  logic [OUTWIDTH-1:0]        gold_out;
  logic                       r_valid;
  logic                       r_ready;
  logic [OUTWIDTH-1:0]        r_class;
  logic                       r_err;
  logic [CNTW-1:0]            sample_cnt;
  logic [CNTW-1:0]            err_cnt;
  logic                       first_err_vld;
  logic [CNTW-1:0]            first_err_idx;
  logic                       cnt_clr;

  modport slave (
    input  s_valid, s_inp, s_label, cmp_sel, dut_out, gold_out, r_ready, cnt_clr,
    output s_ready, dut_inp, r_valid, r_class, r_err,
           sample_cnt, err_cnt, first_err_vld, first_err_idx
  );

  modport master (
    output s_valid, s_inp, s_label, cmp_sel, dut_out, gold_out, r_ready, cnt_clr,
    input  s_ready, dut_inp, r_valid, r_class, r_err,
           sample_cnt, err_cnt, first_err_vld, first_err_idx
  );
endinterface

// File: rtl/mlp_eval_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_eval_sequencer
// Accepts one flattened feature vector per handshake, applies it to the
// combinational classifier through a register, waits SETTLE cycles, captures
// the class, compares it with the latched label or the live golden class and
// streams the result out. Keeps saturating sample/mismatch counters and the
// index of the first mismatch for fault-injection campaigns.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset
//   sq  : mlp_eval_sequencer_if.slave (handshakes, classifier, statistics)
// -----------------------------------------------------------------------------
module mlp_eval_sequencer #(
  parameter int NUM_A    = 16,
  parameter int WIDTH_A  = 4,
  parameter int OUTWIDTH = 4,
  parameter int SETTLE   = 8,
  parameter int CNTW     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  mlp_eval_sequencer_if.slave     sq
);

  localparam int IW = NUM_A * WIDTH_A;
  // Settle counter must hold SETTLE itself; keep at least one bit.
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CNTW-1:0] STAT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] STAT_ONE = CNTW'(1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;

  logic [1:0]          r_state;
  logic [CW-1:0]       r_cnt;
  logic [IW-1:0]       r_dut_inp;
  logic [OUTWIDTH-1:0] r_label;
  logic                r_sel;
  logic                r_res_valid;
  logic [OUTWIDTH-1:0] r_class;
  logic                r_err;
  logic [CNTW-1:0]     r_sample_cnt;
  logic [CNTW-1:0]     r_err_cnt;
  logic                r_first_vld;
  logic [CNTW-1:0]     r_first_idx;

  logic                w_capture;
  logic [OUTWIDTH-1:0] w_ref;
  logic                w_mismatch;

  // Saturating increment for the statistics counters.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    if (v == STAT_MAX) begin
      return v;
    end else begin
      return v + STAT_ONE;
    end
  endfunction

  // Capture happens on the last settle cycle; reference is the latched label
  // or the golden classifier, which sees the same registered dut_inp.
  always_comb begin
    w_capture = (r_state == ST_SETTLE) && (r_cnt == CNT_ONE);
    if (r_sel) begin
      w_ref = sq.gold_out;
    end else begin
      w_ref = r_label;
    end
    w_mismatch = (sq.dut_out != w_ref);
  end

  // Sequencer FSM: accept, settle, emit; dut_inp only changes on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_dut_inp   <= '0;
      r_label     <= '0;
      r_sel       <= 1'b0;
      r_res_valid <= 1'b0;
      r_class     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (sq.s_valid) begin
            r_dut_inp <= sq.s_inp;
            r_label   <= sq.s_label;
            r_sel     <= sq.cmp_sel;
            r_cnt     <= CNT_LOAD;
            r_state   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt == CNT_ONE) begin
            r_class     <= sq.dut_out;
            r_err       <= w_mismatch;
            r_res_valid <= 1'b1;
            r_state     <= ST_EMIT;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_EMIT: begin
          if (sq.r_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Statistics: clear wins over a coincident capture, counters saturate.
  always_ff @(posedge clk) begin
    if (rst || sq.cnt_clr) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_first_vld  <= 1'b0;
      r_first_idx  <= '0;
    end else if (w_capture) begin
      r_sample_cnt <= sat_inc(r_sample_cnt);
      if (w_mismatch) begin
        r_err_cnt <= sat_inc(r_err_cnt);
        if (!r_first_vld) begin
          r_first_vld <= 1'b1;
          r_first_idx <= r_sample_cnt;
        end
      end
    end
  end

  // s_ready is a state decode, held low while reset is asserted.
  assign sq.s_ready       = (r_state == ST_IDLE) && !rst;
  assign sq.dut_inp       = r_dut_inp;
  assign sq.r_valid       = r_res_valid;
  assign sq.r_class       = r_class;
  assign sq.r_err         = r_err;
  assign sq.sample_cnt    = r_sample_cnt;
  assign sq.err_cnt       = r_err_cnt;
  assign sq.first_err_vld = r_first_vld;
  assign sq.first_err_idx = r_first_idx;

endmodule

// File: tb/tb_mlp_eval_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mlp_eval_sequencer
// Directed bench for mlp_eval_sequencer with SETTLE=3 and CNTW=4. The
// classifier and golden model are stubs whose outputs the bench sets per
// sample. Outputs are sampled on the falling edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_mlp_eval_sequencer;

  localparam int SETTLE = 3;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  mlp_eval_sequencer_if #(.NUM_A(16), .WIDTH_A(4), .OUTWIDTH(4), .CNTW(4)) bus ();

  mlp_eval_sequencer #(
    .NUM_A(16), .WIDTH_A(4), .OUTWIDTH(4), .SETTLE(SETTLE), .CNTW(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sq  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full sample: accept, settle, check result and statistics, release.
  task automatic run_sample(
    input logic [63:0] inp, input logic [3:0] label, input logic sel,
    input logic [3:0] dout, input logic [3:0] gold, input logic exp_err,
    input logic [3:0] exp_s, input logic [3:0] exp_e,
    input logic exp_fv, input logic [3:0] exp_fi,
    input bit hold, input bit clr
  );
    int k;
    bus.s_valid  = 1'b1;
    bus.s_inp    = inp;
    bus.s_label  = label;
    bus.cmp_sel  = sel;
    bus.dut_out  = dout;
    bus.gold_out = gold;
    @(negedge clk);
    // Perturb the sample inputs so only latched values can matter.
    bus.s_valid = 1'b0;
    bus.s_inp   = ~inp;
    bus.s_label = ~label;
    bus.cmp_sel = ~sel;
    check("dut_inp_applied", bus.dut_inp, inp);
    check("s_ready_busy", 64'(bus.s_ready), 64'(1'b0));
    check("r_valid_early", 64'(bus.r_valid), 64'(1'b0));
    k = 0;
    while (k < 20 && !bus.r_valid) begin
      if (clr && k == SETTLE - 1) bus.cnt_clr = 1'b1;
      @(negedge clk);
      k++;
    end
    bus.cnt_clr = 1'b0;
    check("capture_latency", 64'(k), 64'(SETTLE));
    check("r_class", 64'(bus.r_class), 64'(dout));
    check("r_err", 64'(bus.r_err), 64'(exp_err));
    check("sample_cnt", 64'(bus.sample_cnt), 64'(exp_s));
    check("err_cnt", 64'(bus.err_cnt), 64'(exp_e));
    check("first_err_vld", 64'(bus.first_err_vld), 64'(exp_fv));
    check("first_err_idx", 64'(bus.first_err_idx), 64'(exp_fi));
    if (hold) begin
      bus.s_valid = 1'b1;
      bus.s_inp   = 64'hDEAD_BEEF_CAFE_F00D;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check("hold_r_valid", 64'(bus.r_valid), 64'(1'b1));
        check("hold_r_class", 64'(bus.r_class), 64'(dout));
        check("hold_s_ready", 64'(bus.s_ready), 64'(1'b0));
      end
      check("hold_dut_inp", bus.dut_inp, inp);
      check("hold_sample_cnt", 64'(bus.sample_cnt), 64'(exp_s));
      bus.s_valid = 1'b0;
    end
    bus.r_ready = 1'b1;
    @(negedge clk);
    bus.r_ready = 1'b0;
    check("release_r_valid", 64'(bus.r_valid), 64'(1'b0));
    check("release_s_ready", 64'(bus.s_ready), 64'(1'b1));
    check("dut_inp_kept", bus.dut_inp, inp);
  endtask

  initial begin
    int pulses;
    logic [3:0] es;
    logic [3:0] ee;
    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_inp    = '0;
    bus.s_label  = '0;
    bus.cmp_sel  = 1'b0;
    bus.dut_out  = '0;
    bus.gold_out = '0;
    bus.r_ready  = 1'b0;
    bus.cnt_clr  = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("s_ready_in_reset", 64'(bus.s_ready), 64'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 64'(bus.s_ready), 64'(1'b1));
    check("rst_r_valid", 64'(bus.r_valid), 64'(1'b0));
    check("rst_dut_inp", bus.dut_inp, 64'h0);
    check("rst_sample_cnt", 64'(bus.sample_cnt), 64'h0);
    check("rst_err_cnt", 64'(bus.err_cnt), 64'h0);
    check("rst_first_vld", 64'(bus.first_err_vld), 64'h0);
    check("rst_first_idx", 64'(bus.first_err_idx), 64'h0);
    check("rst_r_class", 64'(bus.r_class), 64'h0);

    // Samples 0..6: matches, a golden-path mismatch at index 3, a label mismatch at 6
    run_sample(64'h0123_4567_89AB_CDEF, 4'h5, 1'b0, 4'h5, 4'h0, 1'b0, 4'd1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    run_sample(64'hFEDC_BA98_7654_3210, 4'hA, 1'b0, 4'hA, 4'h1, 1'b0, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    run_sample(64'h1111_1111_1111_1111, 4'h0, 1'b1, 4'h6, 4'h6, 1'b0, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    run_sample(64'h2222_2222_2222_2222, 4'h3, 1'b1, 4'h3, 4'h7, 1'b1, 4'd4, 4'd1, 1'b1, 4'd3, 1'b0, 1'b0);
    run_sample(64'h3333_3333_3333_3333, 4'h9, 1'b0, 4'h9, 4'h2, 1'b0, 4'd5, 4'd1, 1'b1, 4'd3, 1'b0, 1'b0);
    run_sample(64'h4444_4444_4444_4444, 4'hC, 1'b0, 4'hC, 4'hC, 1'b0, 4'd6, 4'd1, 1'b1, 4'd3, 1'b0, 1'b0);
    run_sample(64'h5555_5555_5555_5555, 4'h2, 1'b0, 4'h9, 4'h9, 1'b1, 4'd7, 4'd2, 1'b1, 4'd3, 1'b0, 1'b0);

    // 20 mismatching samples: both counters climb to 15 and stick there
    for (int i = 0; i < 20; i++) begin
      es = (8 + i > 15) ? 4'd15 : 4'(8 + i);
      ee = (3 + i > 15) ? 4'd15 : 4'(3 + i);
      run_sample(64'(i) * 64'h0101_0101_0101_0101, 4'h0, 1'b0, 4'h1, 4'h1, 1'b1, es, ee, 1'b1, 4'd3, 1'b0, 1'b0);
    end
    check("sat_sample_cnt", 64'(bus.sample_cnt), 64'd15);
    check("sat_err_cnt", 64'(bus.err_cnt), 64'd15);

    // Clear on the capture edge: sample uncounted, result still produced
    run_sample(64'h6666_6666_6666_6666, 4'h4, 1'b0, 4'h8, 4'h8, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    // First mismatch after the clear lands at index 0
    run_sample(64'h7777_7777_7777_7777, 4'h4, 1'b1, 4'h8, 4'h9, 1'b1, 4'd1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);

    // Reset during SETTLE aborts the sample
    bus.s_valid  = 1'b1;
    bus.s_inp    = 64'h89AB_89AB_89AB_89AB;
    bus.s_label  = 4'h1;
    bus.cmp_sel  = 1'b0;
    bus.dut_out  = 4'h1;
    @(negedge clk);
    bus.s_valid = 1'b0;
    check("abort_dut_inp_applied", bus.dut_inp, 64'h89AB_89AB_89AB_89AB);
    rst = 1'b1;
    @(negedge clk);
    check("abort_dut_inp", bus.dut_inp, 64'h0);
    check("abort_r_valid", 64'(bus.r_valid), 64'(1'b0));
    check("abort_s_ready_in_reset", 64'(bus.s_ready), 64'(1'b0));
    rst = 1'b0;
    @(negedge clk);
    check("abort_s_ready", 64'(bus.s_ready), 64'(1'b1));
    check("abort_sample_cnt", 64'(bus.sample_cnt), 64'd0);
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.r_valid) pulses++;
    end
    check("abort_no_result", 64'(pulses), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
